// File: rtl/microword_executor_if.sv
// Memory request/response bus between the microword executor and memory.
interface microword_executor_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_rd, mem_wr, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_rd, mem_wr, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/microword_executor.sv
// Executes one microword per accepted cycle, stalling the control store
// while a memory access is outstanding.
module microword_executor #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [37:0]       control_signal_i,
    input  logic              word_valid_i,
    input  logic [ADDR_W-1:0] pc_value_i,
    input  logic [ADDR_W-1:0] mar_value_i,
    input  logic [DATA_W-1:0] bus_value_i,
    input  logic [DATA_W-1:0] ac_value_i,
    output logic              hold_o,
    output logic [18:0]       reg_load_o,
    output logic [3:0]        alu_op_o,
    output logic [4:0]        bus_sel_o,
    output logic              ir_load_o,
    output logic [6:0]        mbru_o,
    output logic [DATA_W-1:0] mdr_o,
    output logic              z_flag_o,
    output logic              proto_err_o,
    output logic              timeout_err_o,
    microword_executor_if.master mem
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic {IDLE, WAIT} state_e;
    typedef enum logic [1:0] {M_NONE, M_FETCH, M_READ, M_WRITE} mop_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    mop_e              op_q, op_dec;
    logic              op_bad;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [28:0]       word_q, strb_q, strb_d, fields;
    logic [6:0]        mbru_q;
    logic [DATA_W-1:0] mdr_q;
    logic              z_q, perr_q, terr_q;
    logic              start, done, tmo, accept;

    // {alu_op, reg_load, ir_load, bus_sel}
    assign fields = {control_signal_i[31:9], control_signal_i[5:0]};

    always_comb begin
        op_dec = M_NONE;
        op_bad = 1'b0;
        unique case (control_signal_i[8:6])
            3'b100:  op_dec = M_FETCH;
            3'b010:  op_dec = M_READ;
            3'b001:  op_dec = M_WRITE;
            3'b000:  op_dec = M_NONE;
            default: op_bad = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_o  = 1'b0;
        start   = 1'b0;
        done    = 1'b0;
        tmo     = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (word_valid_i) begin
                    if (op_dec != M_NONE) begin
                        hold_o  = rst_n;
                        start   = 1'b1;
                        state_d = WAIT;
                        cnt_d   = ONE;
                    end else begin
                        accept = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (mem.mem_ack) begin
                    done    = 1'b1;
                    accept  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == TMO) begin
                    tmo     = 1'b1;
                    state_d = IDLE;
                end else begin
                    hold_o = 1'b1;
                    cnt_d  = cnt_q + ONE;
                end
            end
        endcase
    end

    always_comb begin
        strb_d = '0;
        if (accept) strb_d = (state_q == IDLE) ? fields : word_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= M_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            strb_q  <= '0;
            mbru_q  <= '0;
            mdr_q   <= '0;
            z_q     <= 1'b0;
            perr_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            strb_q <= strb_d;
            if (start) begin
                op_q    <= op_dec;
                addr_q  <= (op_dec == M_FETCH) ? pc_value_i : mar_value_i;
                wdata_q <= bus_value_i;
                word_q  <= fields;
            end
            if (done && op_q == M_FETCH) mbru_q <= mem.mem_rdata[6:0];
            if (done && op_q == M_READ)  mdr_q  <= mem.mem_rdata;
            if (tmo) terr_q <= 1'b1;
            if (state_q == IDLE && word_valid_i && op_bad) perr_q <= 1'b1;
            if (strb_q[6]) z_q <= (ac_value_i == '0);
        end
    end

    assign mem.mem_rd    = (state_q == WAIT) &&
                           (op_q == M_FETCH || op_q == M_READ);
    assign mem.mem_wr    = (state_q == WAIT) && (op_q == M_WRITE);
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    assign alu_op_o      = strb_q[28:25];
    assign reg_load_o    = strb_q[24:6];
    assign ir_load_o     = strb_q[5];
    assign bus_sel_o     = strb_q[4:0];
    assign mbru_o        = mbru_q;
    assign mdr_o         = mdr_q;
    assign z_flag_o      = z_q;
    assign proto_err_o   = perr_q;
    assign timeout_err_o = terr_q;
endmodule

// File: tb/tb_microword_executor.sv
// Bench for microword_executor: directed vector table, back-to-back,
// randomized words against a transaction-level model, and mid-WAIT reset.
module tb_microword_executor;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int TO = 4;

    typedef struct {
        logic [37:0] ctrl;
        int          d;
        logic [15:0] pc, mar, bus, rdata, ac;
        int          e_hold, e_rd, e_wr;
        logic [28:0] e_strb;
        logic [6:0]  e_mbru;
        logic [15:0] e_mdr;
        logic        e_z, e_perr, e_terr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [37:0] ctrl;
    logic        wv;
    logic [15:0] pc, mar, bus, ac;
    logic        hold;
    logic [18:0] rl;
    logic [3:0]  alu;
    logic [4:0]  bs;
    logic        ir;
    logic [6:0]  mbru;
    logic [15:0] mdr;
    logic        z, perr, terr;
    int          n_chk = 0;
    int          n_fail = 0;

    logic [6:0]  m_mbru;
    logic [15:0] m_mdr;
    logic        m_z, m_perr, m_terr;
    vec_t        tbl[6];

    microword_executor_if #(.ADDR_W(AW), .DATA_W(DW)) mif();

    microword_executor #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .control_signal_i (ctrl),
        .word_valid_i     (wv),
        .pc_value_i       (pc),
        .mar_value_i      (mar),
        .bus_value_i      (bus),
        .ac_value_i       (ac),
        .hold_o           (hold),
        .reg_load_o       (rl),
        .alu_op_o         (alu),
        .bus_sel_o        (bs),
        .ir_load_o        (ir),
        .mbru_o           (mbru),
        .mdr_o            (mdr),
        .z_flag_o         (z),
        .proto_err_o      (perr),
        .timeout_err_o    (terr),
        .mem              (mif)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [28:0] fld(input logic [37:0] c);
        return {c[31:9], c[5:0]};
    endfunction

    function automatic vec_t mkv(
        input logic [37:0] c, input int d,
        input logic [15:0] pc_, mar_, bus_, rd_, ac_,
        input int eh, er, ew, input logic [28:0] es,
        input logic [6:0] em, input logic [15:0] emd,
        input logic ez, ep, et);
        vec_t v;
        v.ctrl = c;  v.d = d;
        v.pc = pc_;  v.mar = mar_; v.bus = bus_;
        v.rdata = rd_; v.ac = ac_;
        v.e_hold = eh; v.e_rd = er; v.e_wr = ew;
        v.e_strb = es; v.e_mbru = em; v.e_mdr = emd;
        v.e_z = ez; v.e_perr = ep; v.e_terr = et;
        return v;
    endfunction

    // Enter at posedge+1; leaves at posedge+1 after the z_flag update.
    task automatic run_word(input vec_t v, input string nm);
        int hn, rn, wn, req, cyc;
        bit done, aok, sok;
        logic [15:0] ea;
        hn = 0; rn = 0; wn = 0; req = 0; cyc = 0;
        done = 0; aok = 1; sok = 1;
        ea = (v.ctrl[8:6] == 3'b100) ? v.pc : v.mar;
        ctrl = v.ctrl; wv = 1'b1;
        pc = v.pc; mar = v.mar; bus = v.bus; ac = v.ac;
        mif.mem_rdata = v.rdata;
        while (!done && cyc < 20) begin
            if (mif.mem_rd || mif.mem_wr) req++;
            mif.mem_ack = (req == v.d);
            #1;
            if (hold) hn++;
            if (mif.mem_rd) rn++;
            if (mif.mem_wr) wn++;
            if (mif.mem_rd || mif.mem_wr) begin
                if (mif.mem_addr !== ea) aok = 0;
                if (mif.mem_wr && mif.mem_wdata !== v.bus) aok = 0;
            end
            if ({alu, rl, ir, bs} !== 29'h0) sok = 0;
            if (!hold) done = 1;
            cyc++;
            tick();
        end
        chk({nm, ":accept_bound"}, done, 1);
        wv = 1'b0;
        mif.mem_ack = 1'b0;
        #1;
        chk({nm, ":hold_cycles"}, hn, v.e_hold);
        chk({nm, ":rd_cycles"}, rn, v.e_rd);
        chk({nm, ":wr_cycles"}, wn, v.e_wr);
        chk({nm, ":addr_wdata"}, aok, 1);
        chk({nm, ":no_early_strobe"}, sok, 1);
        chk({nm, ":strobes"}, {alu, rl, ir, bs}, v.e_strb);
        chk({nm, ":req_dropped"}, mif.mem_rd | mif.mem_wr, 0);
        chk({nm, ":mbru"}, mbru, v.e_mbru);
        chk({nm, ":mdr"}, mdr, v.e_mdr);
        chk({nm, ":proto_err"}, perr, v.e_perr);
        chk({nm, ":timeout_err"}, terr, v.e_terr);
        tick();
        chk({nm, ":strobe_once"}, {alu, rl, ir, bs}, 29'h0);
        chk({nm, ":z_flag"}, z, v.e_z);
    endtask

    initial begin
        logic [37:0] c0, c1, c2, c3, c4, c5, w1, w2;
        rst_n = 1'b0; ctrl = '0; wv = 1'b0;
        pc = '0; mar = '0; bus = '0; ac = '0;
        mif.mem_ack = 1'b0; mif.mem_rdata = '0;

        c0 = {6'h00, 4'h7, 19'h00001, 3'b000, 1'b0, 5'h00};
        c1 = {6'h3F, 4'h2, 19'h00010, 3'b100, 1'b1, 5'h03};
        c2 = {6'h00, 4'h1, 19'h00001, 3'b001, 1'b0, 5'h1F};
        c3 = {6'h15, 4'hF, 19'h7FFFF, 3'b010, 1'b1, 5'h1F};
        c4 = {6'h00, 4'h3, 19'h00002, 3'b010, 1'b0, 5'h02};
        c5 = {6'h00, 4'h5, 19'h00004, 3'b110, 1'b1, 5'h04};
        tbl[0] = mkv(c0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                     0, 0, 0, fld(c0), 7'd0, 16'h0, 1, 0, 0);
        tbl[1] = mkv(c1, 3, 16'h0040, 16'h0999, 16'h0, 16'h0005,
                     16'h0005, 3, 3, 0, fld(c1), 7'd5, 16'h0,
                     1, 0, 0);
        tbl[2] = mkv(c2, 1, 16'h0777, 16'h0123, 16'h00AB, 16'h0,
                     16'h0001, 1, 0, 1, fld(c2), 7'd5, 16'h0,
                     0, 0, 0);
        tbl[3] = mkv(c3, 99, 16'h0, 16'h0200, 16'h0, 16'hFFFF,
                     16'h0000, 4, 4, 0, 29'h0, 7'd5, 16'h0,
                     0, 0, 1);
        tbl[4] = mkv(c4, 2, 16'h0, 16'h0300, 16'h0, 16'hBEEF,
                     16'h0000, 2, 2, 0, fld(c4), 7'd5, 16'hBEEF,
                     0, 0, 1);
        tbl[5] = mkv(c5, 0, 16'h0, 16'h0400, 16'h0, 16'h1234,
                     16'h0000, 0, 0, 0, fld(c5), 7'd5, 16'hBEEF,
                     0, 1, 1);

        repeat (2) @(posedge clk);
        #1;
        chk("reset:hold", hold, 0);
        chk("reset:req", mif.mem_rd | mif.mem_wr, 0);
        chk("reset:strobes", {alu, rl, ir, bs}, 29'h0);
        chk("reset:flags", {z, perr, terr}, 3'b000);
        chk("reset:mbru_mdr", {mbru, mdr}, 23'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_word(tbl[i], $sformatf("vec%0d", i));

        w1 = {6'h00, 4'h9, 19'h00100, 3'b000, 1'b1, 5'h11};
        w2 = {6'h00, 4'hA, 19'h00200, 3'b000, 1'b0, 5'h12};
        ctrl = w1; wv = 1'b1;
        #1;
        chk("b2b:hold0", hold, 0);
        tick();
        ctrl = w2;
        #1;
        chk("b2b:strobe1", {alu, rl, ir, bs}, fld(w1));
        chk("b2b:hold1", hold, 0);
        tick();
        wv = 1'b0;
        #1;
        chk("b2b:strobe2", {alu, rl, ir, bs}, fld(w2));
        tick();
        chk("b2b:idle", {alu, rl, ir, bs}, 29'h0);

        m_mbru = tbl[5].e_mbru; m_mdr = tbl[5].e_mdr;
        m_z = tbl[5].e_z; m_perr = tbl[5].e_perr; m_terr = tbl[5].e_terr;
        for (int i = 0; i < 40; i++) begin
            vec_t v;
            logic [2:0] m;
            logic [1:0] t;
            bit legal, tmo;
            int hc;
            case ($urandom_range(0, 4))
                0: m = 3'b000;
                1: m = 3'b100;
                2: m = 3'b010;
                3: m = 3'b001;
                default: begin
                    t = 2'($urandom_range(0, 3));
                    m = (t == 2'd0) ? 3'b011 : {1'b1, t};
                end
            endcase
            v.ctrl = {6'($urandom), 4'($urandom), 19'($urandom), m,
                      1'($urandom), 5'($urandom)};
            v.pc = 16'($urandom); v.mar = 16'($urandom);
            v.bus = 16'($urandom); v.rdata = 16'($urandom);
            v.ac = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            legal = (m == 3'b100) || (m == 3'b010) || (m == 3'b001);
            v.d = legal ? $urandom_range(1, 6) : $urandom_range(0, 1) * 3;
            tmo = legal && (v.d > TO);
            hc = legal ? (tmo ? TO : v.d) : 0;
            v.e_hold = hc;
            v.e_rd = (m == 3'b100 || m == 3'b010) ? hc : 0;
            v.e_wr = (m == 3'b001) ? hc : 0;
            v.e_strb = tmo ? 29'h0 : fld(v.ctrl);
            if (!tmo && m == 3'b100) m_mbru = v.rdata[6:0];
            if (!tmo && m == 3'b010) m_mdr = v.rdata;
            if (!legal && m != 3'b000) m_perr = 1'b1;
            if (tmo) m_terr = 1'b1;
            if (!tmo && v.ctrl[9]) m_z = (v.ac == 16'h0);
            v.e_mbru = m_mbru; v.e_mdr = m_mdr;
            v.e_z = m_z; v.e_perr = m_perr; v.e_terr = m_terr;
            run_word(v, $sformatf("rand%0d", i));
        end

        ctrl = {6'h00, 4'h6, 19'h00001, 3'b010, 1'b0, 5'h06};
        mar = 16'h0555; wv = 1'b1;
        tick();
        tick();
        #1;
        chk("rst:rd_before", mif.mem_rd, 1);
        chk("rst:hold_before", hold, 1);
        rst_n = 1'b0;
        #1;
        chk("rst:rd_async", mif.mem_rd | mif.mem_wr, 0);
        chk("rst:hold_async", hold, 0);
        chk("rst:addr", {mif.mem_addr, mif.mem_wdata}, 32'h0);
        chk("rst:strobes", {alu, rl, ir, bs}, 29'h0);
        chk("rst:flags", {z, perr, terr}, 3'b000);
        chk("rst:mbru_mdr", {mbru, mdr}, 23'h0);
        wv = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("rst:idle_after", mif.mem_rd | mif.mem_wr | hold, 0);
        c0 = {6'h00, 4'h4, 19'h00001, 3'b000, 1'b1, 5'h07};
        run_word(mkv(c0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                     0, 0, 0, fld(c0), 7'd0, 16'h0, 1, 0, 0),
                 "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/microword_executor.md
MICROWORD_EXECUTOR -- requirements
Module: microword_executor

Interface
REQ-001 Parameter DATA_W, default 16: datapath/memory data width.
REQ-002 Parameter ADDR_W, default 16: memory address width.
REQ-003 Parameter TIMEOUT, default 255: maximum WAIT cycles before memory abort.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 control_signal  in  38  microword; [37:32] next-addr (ignored), [31:28] alu op, [27:9] register loads, [8:6] memory op, [5] IR load, [4:0] bus select.
REQ-007 word_valid  in  1  control_signal presents a new word this cycle.
REQ-008 pc_value / mar_value  in  ADDR_W each  fetch address / data address.
REQ-009 bus_value  in  DATA_W  write data source.
REQ-010 ac_value  in  DATA_W  accumulator next value, for Z.
REQ-011 hold  out  1  stall to control store; store keeps the current word while high.
REQ-012 reg_load  out  19  register load strobes; alu_op out 4; bus_sel out 5; ir_load out 1.
REQ-013 mem_rd, mem_wr  out  1 each; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_ack in 1; mem_rdata in DATA_W.
REQ-014 mbru  out  7  opcode from the last fetch; mdr out DATA_W, data from the last data read.
REQ-015 z_flag  out  1; proto_err, timeout_err  out  1 each, sticky.

Function
REQ-016 Memory op decode of [8:6]: 100 fetch read, 010 data read, 001 data write, 000 none; any other value is illegal.
REQ-017 FSM states IDLE, WAIT.
REQ-018 Word acceptance:
  - IDLE, word_valid, op none/illegal: accepted that cycle.
  - IDLE, word_valid, legal op: latch word, address (pc_value for fetch, else mar_value) and bus_value; go to WAIT.
REQ-019 In WAIT, mem_rd (read ops) or mem_wr (write) is high from the first WAIT cycle; mem_addr and mem_wdata hold the latched values and stay stable until the ack.
REQ-020 In WAIT with mem_ack high:
  - fetch: mbru <= mem_rdata[6:0]; data read: mdr <= mem_rdata.
  - Request drops next cycle; state returns to IDLE; the word counts as accepted this cycle.
REQ-021 hold = (IDLE && word_valid && legal op) || (WAIT && !mem_ack && not timing out); combinational.
REQ-022 In the cycle after acceptance, reg_load = word[27:9], alu_op = word[31:28], bus_sel = word[4:0], ir_load = word[5] for exactly one cycle; all are 0 otherwise.
REQ-023 Latency: a non-memory word is accepted in 1 cycle; a memory word takes N+1 cycles to accept, where N is the number of WAIT cycles including the ack cycle.
REQ-024 WAIT counter counts from 1; when it reaches TIMEOUT with no ack:
  - Return to IDLE and set timeout_err.
  - hold is low that cycle; no strobes are issued; mbru/mdr are unchanged.
REQ-025 An illegal memory op sets proto_err; no memory access occurs; strobes are still issued.
REQ-026 z_flag <= (ac_value == 0) on any edge where reg_load[0] is high; otherwise it holds.
REQ-027 mem_ack in IDLE is ignored; word_valid during WAIT is ignored.
REQ-028 A new word may be accepted in the same cycle the previous word's strobes are output (back-to-back, one word per cycle).

Reset
REQ-029 rst_n low immediately forces:
  - state IDLE;
  - all outputs 0, including mbru, mdr, z_flag, and both error flags;
  - mem_rd/mem_wr drop asynchronously, even mid-WAIT.
REQ-030 An access interrupted by reset is abandoned; after release the block waits in IDLE for word_valid.

Verification
REQ-031 IDLE, word with alu_op=0111, reg_load bit0=1, mem=000, ac_value=0 -> next cycle reg_load=19'h1, alu_op=4'h7, hold never high; following cycle z_flag=1.
REQ-032 Fetch word, pc_value=0x0040, mem_ack after 3 WAIT cycles, mem_rdata=0x0005 -> mem_rd high 3 cycles, mem_addr=0x0040; hold high 3 cycles; mbru=7'd5; strobes pulse once after the ack.
REQ-033 Data write, mar_value=0x0123, bus_value=0x00AB, ack in first WAIT cycle -> mem_wr one cycle, mem_addr=0x0123, mem_wdata=0x00AB, hold high 1 cycle.
REQ-034 TIMEOUT=4, data read, no ack -> mem_rd high 4 cycles, then drops; timeout_err=1; no strobes; mdr unchanged.
REQ-035 mem field=110 -> proto_err=1, no mem_rd/mem_wr, strobes issued next cycle.
REQ-036 rst_n low on the 2nd WAIT cycle of a read -> mem_rd and hold low immediately; all outputs 0; after release, a plain word decodes normally.
